// File: rtl/fwd_track_if.sv
// Pipeline-side bundle for fwd_track_unit: ID/EX request, stage write data, forward results.
// FWD_TRACK_STATS_EN adds the fwd_cnt/stall_cnt statistics outputs.
interface fwd_track_if #(
  parameter int REG_AW  = 3,
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH+1)
);
  logic                        adv;
  logic                        flush;
  logic                        id_valid;
  logic                        id_wr_en;
  logic [REG_AW-1:0]           id_wr_reg;
  logic                        id_is_load;
  logic [NUM_SRC*REG_AW-1:0]   src_reg;
  logic [NUM_SRC-1:0]          src_vld;
  logic [NUM_SRC*DATA_W-1:0]   src_rf_data;
  logic [DEPTH*DATA_W-1:0]     stage_data;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   operand;
  logic                        ld_stall;
`ifdef FWD_TRACK_STATS_EN
  logic [31:0]                 fwd_cnt;
  logic [31:0]                 stall_cnt;
`endif

  modport master (
    output adv, flush, id_valid, id_wr_en, id_wr_reg, id_is_load,
           src_reg, src_vld, src_rf_data, stage_data,
    input  fwd_sel, operand, ld_stall
`ifdef FWD_TRACK_STATS_EN
    , input fwd_cnt, stall_cnt
`endif
  );

  modport slave (
    input  adv, flush, id_valid, id_wr_en, id_wr_reg, id_is_load,
           src_reg, src_vld, src_rf_data, stage_data,
    output fwd_sel, operand, ld_stall
`ifdef FWD_TRACK_STATS_EN
    , output fwd_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/fwd_track_unit.sv
// EX-stage forwarding unit that tracks in-flight destinations itself; youngest producer wins.
// Optional statistics counters are enabled with FWD_TRACK_STATS_EN.

// Per-source resolver: picks the youngest matching stage and flags an unready load.
module fwd_track_src #(
  parameter int REG_AW     = 3,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic [REG_AW-1:0]             src_reg,
  input  logic                          src_vld,
  input  logic [DATA_W-1:0]             rf_data,
  input  logic [DEPTH-1:0]              ent_v,
  input  logic [DEPTH-1:0][REG_AW-1:0]  ent_reg,
  input  logic [DEPTH-1:0]              ent_ld,
  input  logic [DEPTH-1:0][DATA_W-1:0]  stage_data,
  output logic [SEL_W-1:0]              sel,
  output logic [DATA_W-1:0]             operand,
  output logic                          not_ready
);
  // Scan oldest to youngest so the last hit (lowest stage) overrides older ones.
  always_comb begin
    sel       = '0;
    operand   = rf_data;
    not_ready = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_vld && ent_v[k-1] && (src_reg == ent_reg[k-1])) begin
        sel       = SEL_W'(k);
        operand   = stage_data[k-1];
        not_ready = ent_ld[k-1] && (k < LOAD_STAGE);
      end
    end
  end
endmodule

module fwd_track_unit #(
  parameter int REG_AW     = 3,
  parameter int DATA_W     = 16,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic       clk,
  input  logic       rst,
  fwd_track_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rg;
    logic              ld;
  } ent_t;

  ent_t [DEPTH-1:0]                ent;
  ent_t                            id_req;
  logic [DEPTH-1:0]                ent_v;
  logic [DEPTH-1:0][REG_AW-1:0]    ent_reg;
  logic [DEPTH-1:0]                ent_ld;
  logic [NUM_SRC-1:0][REG_AW-1:0]  src_reg_a;
  logic [NUM_SRC-1:0][DATA_W-1:0]  rf_a;
  logic [DEPTH-1:0][DATA_W-1:0]    stage_a;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
  logic [NUM_SRC-1:0][DATA_W-1:0]  opnd;
  logic [NUM_SRC-1:0]              not_ready;
  logic                            stall;

  assign src_reg_a = bus.src_reg;
  assign rf_a      = bus.src_rf_data;
  assign stage_a   = bus.stage_data;

  // A stalled or flushed ID/EX slot enters stage 1 as a bubble.
  assign id_req.v  = bus.id_valid & bus.id_wr_en & ~stall & ~bus.flush;
  assign id_req.rg = bus.id_wr_reg;
  assign id_req.ld = bus.id_is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) ent[k].v <= 1'b0;
    end else if (bus.adv) begin
      ent[0] <= id_req;
      for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_v[k]   = ent[k].v;
    assign ent_reg[k] = ent[k].rg;
    assign ent_ld[k]  = ent[k].ld;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_track_src #(
      .REG_AW(REG_AW), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
    ) u_src (
      .src_reg   (src_reg_a[i]),
      .src_vld   (bus.src_vld[i]),
      .rf_data   (rf_a[i]),
      .ent_v     (ent_v),
      .ent_reg   (ent_reg),
      .ent_ld    (ent_ld),
      .stage_data(stage_a),
      .sel       (sel[i]),
      .operand   (opnd[i]),
      .not_ready (not_ready[i])
    );
  end

  assign stall        = bus.id_valid & ~bus.flush & (|not_ready);
  assign bus.ld_stall = stall;
  assign bus.fwd_sel  = sel;
  assign bus.operand  = opnd;

`ifdef FWD_TRACK_STATS_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q, fwd_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sel[i] != '0) fwd_inc = fwd_inc + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (bus.adv) begin
      if (stall)             stall_cnt_q <= sat_add(stall_cnt_q, 32'd1);
      else if (bus.id_valid) fwd_cnt_q   <= sat_add(fwd_cnt_q, fwd_inc);
    end
  end

  assign bus.fwd_cnt   = fwd_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_track_unit.sv
// Directed bench for fwd_track_unit: an in-flight instruction list model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fwd_track_unit;
  localparam int REG_AW = 3, DATA_W = 16, NUM_SRC = 2, DEPTH = 2, LOAD_STAGE = 2;
  localparam int SEL_W = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_track_if #(.REG_AW(REG_AW), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus();

  fwd_track_unit #(
    .REG_AW(REG_AW), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // What occupies each downstream stage: does it write, which register, is it a load.
  typedef struct {bit v; int r; bit ld;} inst_t;
  inst_t m [1:DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src_r(input int i);
    return int'(bus.src_reg[i*REG_AW +: REG_AW]);
  endfunction

  // Youngest in-flight writer of the source register, or 0.
  function automatic int exp_sel(input int i);
    for (int k = 1; k <= DEPTH; k++)
      if (bus.src_vld[i] && m[k].v && m[k].r == src_r(i)) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int k = exp_sel(i);
      if (k != 0 && m[k].ld && k < LOAD_STAGE) s = 1'b1;
    end
    return bus.id_valid && !bus.flush && s;
  endfunction

  function automatic logic [DATA_W-1:0] exp_op(input int i);
    int k = exp_sel(i);
    if (k == 0) return bus.src_rf_data[i*DATA_W +: DATA_W];
    return bus.stage_data[(k-1)*DATA_W +: DATA_W];
  endfunction

  function automatic int sel(input int i);
    return int'(bus.fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  function automatic logic [DATA_W-1:0] op(input int i);
    return bus.operand[i*DATA_W +: DATA_W];
  endfunction

  initial for (int k = 1; k <= DEPTH; k++) m[k].v = 1'b0;

  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) m[k].v <= 1'b0;
    end else if (bus.adv) begin
      m[1] <= '{v: bus.id_valid && bus.id_wr_en && !st && !bus.flush,
                r: int'(bus.id_wr_reg), ld: bus.id_is_load};
      for (int k = 2; k <= DEPTH; k++) m[k] <= m[k-1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        chk($sformatf("model_sel%0d", i), 64'(sel(i)), 64'(exp_sel(i)));
        chk($sformatf("model_op%0d", i), 64'(op(i)), 64'(exp_op(i)));
      end
      chk("model_stall", 64'(bus.ld_stall), 64'(exp_stall()));
    end
  end

  task automatic issue(input bit adv, input bit fl, input bit iv, input bit we,
                       input int wr, input bit ld, input int s0, input int s1,
                       input bit v0, input bit v1);
    @(posedge clk);
    #1;
    bus.adv        = adv;
    bus.flush      = fl;
    bus.id_valid   = iv;
    bus.id_wr_en   = we;
    bus.id_wr_reg  = REG_AW'(wr);
    bus.id_is_load = ld;
    bus.src_reg    = {REG_AW'(s1), REG_AW'(s0)};
    bus.src_vld    = {v1, v0};
    #2;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Writers and loads have no live sources; readers write nothing.
  task automatic wr_op(input int r, input bit ld);
    issue(1, 0, 1, 1, r, ld, 0, 0, 0, 0);
  endtask

  task automatic rd_op(input bit adv, input bit fl, input int r);
    issue(adv, fl, 1, 0, 0, 0, r, 0, 1, 0);
  endtask

  initial begin
    bus.adv = 1'b1; bus.flush = 1'b0; bus.id_valid = 1'b0; bus.id_wr_en = 1'b0;
    bus.id_wr_reg = '0; bus.id_is_load = 1'b0; bus.src_reg = '0; bus.src_vld = '0;
    bus.src_rf_data = {16'hBBBB, 16'hAAAA};
    bus.stage_data  = {16'h2222, 16'h1111};
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    idle(1);
    chk("reset_stall", 64'(bus.ld_stall), 64'(0));
    chk("reset_sel0", 64'(sel(0)), 64'(0));

    // ALU writer then two readers of r3.
    wr_op(3, 0);
    rd_op(1, 0, 3);
    chk("alu_sel_ex", 64'(sel(0)), 64'(1));
    chk("alu_op_ex", 64'(op(0)), 64'(16'h1111));
    rd_op(1, 0, 3);
    chk("alu_sel_mem", 64'(sel(0)), 64'(2));
    chk("alu_op_mem", 64'(op(0)), 64'(16'h2222));
    idle(2);

    // Two writers of r3: youngest wins, duplicate sources agree.
    wr_op(3, 0);
    wr_op(3, 0);
    issue(1, 0, 1, 0, 0, 0, 3, 3, 1, 1);
    chk("prio_sel1", 64'(sel(1)), 64'(1));
    chk("prio_op1", 64'(op(1)), 64'(16'h1111));
    chk("dup_sel0", 64'(sel(0)), 64'(1));
    idle(2);

    // Load-use: one stall, then forward the load data from stage 2.
    wr_op(5, 1);
    rd_op(1, 0, 5);
    chk("lu_stall", 64'(bus.ld_stall), 64'(1));
    rd_op(1, 0, 5);
    chk("lu_release", 64'(bus.ld_stall), 64'(0));
    chk("lu_sel", 64'(sel(0)), 64'(2));
    chk("lu_op", 64'(op(0)), 64'(16'h2222));
    idle(2);

    // Load-use held by three frozen cycles.
    wr_op(5, 1);
    for (int j = 0; j < 3; j++) begin
      rd_op(0, 0, 5);
      chk("frz_stall", 64'(bus.ld_stall), 64'(1));
    end
    chk("frz_sel", 64'(sel(0)), 64'(1));
    rd_op(1, 0, 5);
    chk("frz_adv_stall", 64'(bus.ld_stall), 64'(1));
    rd_op(1, 0, 5);
    chk("frz_release", 64'(bus.ld_stall), 64'(0));
    chk("frz_sel2", 64'(sel(0)), 64'(2));
    idle(2);

    // Unread source never forwards.
    wr_op(6, 0);
    issue(1, 0, 1, 0, 0, 0, 6, 0, 0, 0);
    chk("novld_sel", 64'(sel(0)), 64'(0));
    chk("novld_op", 64'(op(0)), 64'(16'hAAAA));
    idle(2);

    // Flush beats the load-use stall.
    wr_op(5, 1);
    rd_op(1, 1, 5);
    chk("flush_stall", 64'(bus.ld_stall), 64'(0));
    rd_op(1, 0, 5);
    chk("flush_next_sel", 64'(sel(0)), 64'(2));
    idle(2);

    // A flushed writer leaves nothing behind.
    issue(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
    rd_op(1, 0, 2);
    chk("flushwr_sel_a", 64'(sel(0)), 64'(0));
    rd_op(1, 0, 2);
    chk("flushwr_sel_b", 64'(sel(0)), 64'(0));
    idle(2);

    // Invalid ID/EX slot: selects still computed, no stall.
    wr_op(4, 1);
    issue(1, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    chk("inval_stall", 64'(bus.ld_stall), 64'(0));
    chk("inval_sel", 64'(sel(0)), 64'(1));
    idle(1);

    // Reset with a live writer in flight.
    wr_op(3, 0);
    rd_op(1, 0, 3);
    chk("prerst_sel", 64'(sel(0)), 64'(1));
    rst = 1'b1;
    rd_op(1, 0, 3);
    chk("rst_sel", 64'(sel(0)), 64'(0));
    chk("rst_stall", 64'(bus.ld_stall), 64'(0));
    rst = 1'b0;

`ifdef FWD_TRACK_STATS_EN
    chk("rst_fwd_cnt", 64'(bus.fwd_cnt), 64'(0));
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    idle(1);
    wr_op(1, 0);
    issue(1, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    rd_op(1, 0, 1);
    wr_op(7, 1);
    rd_op(1, 0, 7);
    idle(2);
    chk("fwd_cnt", 64'(bus.fwd_cnt), 64'(3));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(1));
`endif

    idle(1);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
